if_stage: RTL

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the program counter, issues word reads to instruction memory through a req/ready handshake, and loads the IF/ID pipeline register that feeds the decoder and control unit. Handles stalls from hazard detection (`freeze`) and redirects and flushes from resolved branches and jumps (`br_taken`/`br_addr`).

---
 rtl/if_stage_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 43 ++++
 rtl/if_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// ============================================================================
// if_stage_pkg : shared fetch-stage configuration (word width, NOP, reset PC,
//                FSM state encodings).  Revision 1.0
// ============================================================================
`default_nettype none

package if_stage_pkg;

  localparam int          CFG_WORD_LEN = 32;
  localparam logic [31:0] CFG_NOP      = 32'h0000_0000;
  localparam logic [31:0] CFG_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    IF_FETCH = 1'b0,
    IF_HOLD  = 1'b1
  } if_state_e;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// if_id_reg : IF/ID pipeline register with load, flush (priority) and hold.
//             Revision 1.0
// ============================================================================
`default_nettype none

module if_id_reg
  import if_stage_pkg::*;
#(
  parameter int WORD_LEN = CFG_WORD_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                flush,
  input  logic [WORD_LEN-1:0] instr_in,
  input  logic [WORD_LEN-1:0] pc_plus4_in,
  output logic [WORD_LEN-1:0] instruction,
  output logic [WORD_LEN-1:0] pc_plus4,
  output logic                valid
);

  localparam logic [WORD_LEN-1:0] C_NOP = WORD_LEN'(CFG_NOP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction <= C_NOP;
      pc_plus4    <= '0;
      valid       <= 1'b0;
    end else if (flush) begin
      instruction <= C_NOP;
      pc_plus4    <= '0;
      valid       <= 1'b0;
    end else if (load) begin
      instruction <= instr_in;
      pc_plus4    <= pc_plus4_in;
      valid       <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// if_stage : MIPS instruction fetch - PC, req/ready fetch FSM, skid buffer.
//            Optional perf counters when IF_PERF_CNT_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter int                   WORD_LEN = CFG_WORD_LEN,
  parameter logic [WORD_LEN-1:0]  RESET_PC = WORD_LEN'(CFG_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                br_taken,
  input  logic [WORD_LEN-1:0] br_addr,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic [WORD_LEN-1:0] imem_rdata,
  input  logic                imem_ready,
  output logic [WORD_LEN-1:0] instruction,
  output logic [WORD_LEN-1:0] pc_plus4,
  output logic                valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [WORD_LEN-1:0] fetch_cnt,
  output logic [WORD_LEN-1:0] stall_cnt
`endif
);

  localparam logic [WORD_LEN-1:0] C_PC_STEP   = WORD_LEN'(4);
  localparam logic [WORD_LEN-1:0] C_ALIGN_MSK = ~WORD_LEN'(3);

  if_state_e           r_state, w_state_next;
  logic [WORD_LEN-1:0] r_pc, w_pc_next;
  logic [WORD_LEN-1:0] r_skid, w_skid_next;
  logic [WORD_LEN-1:0] w_pc_plus4;
  logic [WORD_LEN-1:0] w_load_instr;
  logic                w_load;
  logic                w_flush;

  assign w_pc_plus4 = r_pc + C_PC_STEP;

  // Request is suppressed while reset is held, otherwise purely a state decode.
  assign imem_req  = (r_state == IF_FETCH) && rst;
  assign imem_addr = r_pc;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_skid_next  = r_skid;
    w_load       = 1'b0;
    w_flush      = 1'b0;
    w_load_instr = imem_rdata;
    if (br_taken) begin
      w_pc_next    = br_addr & C_ALIGN_MSK;
      w_flush      = 1'b1;
      w_state_next = IF_FETCH;
    end else begin
      case (r_state)
        IF_FETCH: begin
          if (imem_ready) begin
            if (freeze) begin
              w_skid_next  = imem_rdata;
              w_state_next = IF_HOLD;
            end else begin
              w_load    = 1'b1;
              w_pc_next = w_pc_plus4;
            end
          end
        end
        IF_HOLD: begin
          if (!freeze) begin
            w_load       = 1'b1;
            w_load_instr = r_skid;
            w_pc_next    = w_pc_plus4;
            w_state_next = IF_FETCH;
          end
        end
        default: w_state_next = IF_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IF_FETCH;
      r_pc    <= RESET_PC;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_skid  <= w_skid_next;
    end
  end

  if_id_reg #(
    .WORD_LEN (WORD_LEN)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (w_load),
    .flush       (w_flush),
    .instr_in    (w_load_instr),
    .pc_plus4_in (w_pc_plus4),
    .instruction (instruction),
    .pc_plus4    (pc_plus4),
    .valid       (valid)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (w_load)
        fetch_cnt <= fetch_cnt + WORD_LEN'(1);
      if (freeze || (imem_req && !imem_ready))
        stall_cnt <= stall_cnt + WORD_LEN'(1);
    end
  end
`endif

endmodule

`default_nettype wire
